// File: rtl/vga_pixel_renderer.sv
// Pixel back end: issues the tile/sprite ROM read, maps the returned colour index
// through a writable 16-entry palette and registers RGB aligned to the delayed show-enable.
module vga_pixel_renderer #(
  parameter int unsigned BLINK_FRAMES = 8,
  parameter logic [3:0]  BLINK_IDX    = 4'd9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_ce,
  input  logic        i_frame_start,
  input  logic        i_show_en,
  input  logic [1:0]  i_mem_select,
  input  logic [7:0]  i_tile_code,
  input  logic [5:0]  i_tile_offset,
  output logic [13:0] o_rom_addr,
  output logic        o_rom_sel,
  input  logic [3:0]  i_rom_data,
  input  logic        i_pal_we,
  input  logic [3:0]  i_pal_addr,
  input  logic [23:0] i_pal_data,
  output logic [7:0]  o_vga_r,
  output logic [7:0]  o_vga_g,
  output logic [7:0]  o_vga_b,
  output logic        o_show_en
);

  localparam int unsigned CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

  localparam logic [23:0] PAL_INIT [16] = '{
    24'h000000, 24'hFF0000, 24'hFFB8FF, 24'h00FFFF,
    24'hFFB852, 24'hFFFF00, 24'h2121FF, 24'hFFFFFF,
    24'hDEDEFF, 24'hFFB8AE, 24'h000000, 24'h000000,
    24'h000000, 24'h000000, 24'h000000, 24'h000000
  };

  logic [13:0]   rom_addr_q;
  logic          rom_sel_q;
  logic          blank_a_q;
  logic          show_a_q;
  logic [23:0]   rgb_q, rgb_d;
  logic          show_q;
  logic [CW-1:0] frame_cnt_q;
  logic          blink_q;
  logic [23:0]   pal_q [16];
  logic [3:0]    idx;

  // Stage A: address issue. o_rom_sel doubles as the stage-A ROM-select tag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rom_addr_q <= '0;
      rom_sel_q  <= 1'b0;
      blank_a_q  <= 1'b0;
      show_a_q   <= 1'b0;
    end else if (i_pix_ce) begin
      rom_addr_q <= {i_tile_code, i_tile_offset};
      rom_sel_q  <= i_mem_select[0];
      blank_a_q  <= i_mem_select[1];
      show_a_q   <= i_show_en;
    end
  end

  always_comb begin
    idx = blank_a_q ? 4'd0 : i_rom_data;
    if (!rom_sel_q && (idx == BLINK_IDX) && blink_q)
      idx = 4'd0;
    rgb_d = show_a_q ? pal_q[idx] : 24'h000000;
  end

  // Stage B: colour lookup. The palette read sees the pre-write value of this clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rgb_q  <= '0;
      show_q <= 1'b0;
    end else if (i_pix_ce) begin
      rgb_q  <= rgb_d;
      show_q <= show_a_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 16; i++)
        pal_q[i] <= PAL_INIT[i];
    end else if (i_pal_we) begin
      pal_q[i_pal_addr] <= i_pal_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (i_frame_start) begin
      if (frame_cnt_q == CNT_LAST) begin
        frame_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign o_rom_addr = rom_addr_q;
  assign o_rom_sel  = rom_sel_q;
  assign o_vga_r    = rgb_q[23:16];
  assign o_vga_g    = rgb_q[15:8];
  assign o_vga_b    = rgb_q[7:0];
  assign o_show_en  = show_q;

endmodule

// File: tb/tb_vga_pixel_renderer.sv
// Directed bench for vga_pixel_renderer: vector table plus hold, blink, palette and reset sequences.
module tb_vga_pixel_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_pix_ce, i_frame_start, i_show_en, i_pal_we;
  logic [1:0]  i_mem_select;
  logic [7:0]  i_tile_code;
  logic [5:0]  i_tile_offset;
  logic [3:0]  i_rom_data, i_pal_addr;
  logic [23:0] i_pal_data;
  logic [13:0] o_rom_addr;
  logic        o_rom_sel, o_show_en;
  logic [7:0]  o_vga_r, o_vga_g, o_vga_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_pixel_renderer #(.BLINK_FRAMES(8), .BLINK_IDX(4'd9)) dut (
    .i_clk(clk), .i_rst(rst), .i_pix_ce(i_pix_ce), .i_frame_start(i_frame_start),
    .i_show_en(i_show_en), .i_mem_select(i_mem_select), .i_tile_code(i_tile_code),
    .i_tile_offset(i_tile_offset), .o_rom_addr(o_rom_addr), .o_rom_sel(o_rom_sel),
    .i_rom_data(i_rom_data), .i_pal_we(i_pal_we), .i_pal_addr(i_pal_addr),
    .i_pal_data(i_pal_data), .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b),
    .o_show_en(o_show_en)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  code;
    logic [5:0]  off;
    logic        show;
    logic [3:0]  rom;
    logic [13:0] addr;
    logic        rsel;
    logic [23:0] rgb;
    logic        eshow;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  // One request: stage-A ce, idle clk with ROM data, stage-B ce, idle clk.
  task automatic run_vec(input vec_t v, input string tag, input logic pal_wr);
    i_mem_select = v.sel; i_tile_code = v.code; i_tile_offset = v.off; i_show_en = v.show;
    i_pix_ce = 1'b1;
    clk1;
    check({tag, " addr"}, 32'(o_rom_addr), 32'(v.addr));
    check({tag, " rsel"}, 32'(o_rom_sel), 32'(v.rsel));
    i_pix_ce = 1'b0;
    i_rom_data = v.rom;
    clk1;
    i_pix_ce = 1'b1;
    if (pal_wr) begin
      i_pal_we = 1'b1; i_pal_addr = 4'd3; i_pal_data = 24'h123456;
    end
    clk1;
    i_pal_we = 1'b0;
    check({tag, " rgb"}, 32'({o_vga_r, o_vga_g, o_vga_b}), 32'(v.rgb));
    check({tag, " show"}, 32'(o_show_en), 32'(v.eshow));
    i_pix_ce = 1'b0;
    clk1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      i_frame_start = 1'b1;
      clk1;
      i_frame_start = 1'b0;
      clk1;
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic [7:0] code, input logic [5:0] off,
                              input logic show, input logic [3:0] rom, input logic [13:0] addr,
                              input logic rsel, input logic [23:0] rgb, input logic eshow);
    vec_t v;
    v.sel = sel; v.code = code; v.off = off; v.show = show; v.rom = rom;
    v.addr = addr; v.rsel = rsel; v.rgb = rgb; v.eshow = eshow;
    return v;
  endfunction

  initial begin
    vt[0]  = mk(2'd0, 8'h12, 6'h05, 1'b1, 4'd7,  14'h0485, 1'b0, 24'hFFFFFF, 1'b1);
    vt[1]  = mk(2'd0, 8'h12, 6'h05, 1'b0, 4'd7,  14'h0485, 1'b0, 24'h000000, 1'b0);
    vt[2]  = mk(2'd2, 8'h12, 6'h05, 1'b1, 4'd7,  14'h0485, 1'b0, 24'h000000, 1'b1);
    vt[3]  = mk(2'd1, 8'hAB, 6'h3F, 1'b1, 4'd2,  14'h2AFF, 1'b1, 24'hFFB8FF, 1'b1);
    vt[4]  = mk(2'd3, 8'hFF, 6'h3F, 1'b1, 4'd5,  14'h3FFF, 1'b1, 24'h000000, 1'b1);
    vt[5]  = mk(2'd0, 8'h00, 6'h00, 1'b1, 4'd6,  14'h0000, 1'b0, 24'h2121FF, 1'b1);
    vt[6]  = mk(2'd1, 8'h80, 6'h20, 1'b1, 4'd4,  14'h2020, 1'b1, 24'hFFB852, 1'b1);
    vt[7]  = mk(2'd0, 8'h01, 6'h01, 1'b1, 4'd9,  14'h0041, 1'b0, 24'hFFB8AE, 1'b1);
    vt[8]  = mk(2'd0, 8'h34, 6'h12, 1'b1, 4'd8,  14'h0D12, 1'b0, 24'hDEDEFF, 1'b1);
    vt[9]  = mk(2'd1, 8'h55, 6'h2A, 1'b1, 4'd15, 14'h156A, 1'b1, 24'h000000, 1'b1);
    vt[10] = mk(2'd0, 8'h7F, 6'h11, 1'b1, 4'd1,  14'h1FD1, 1'b0, 24'hFF0000, 1'b1);
    vt[11] = mk(2'd1, 8'h02, 6'h3C, 1'b1, 4'd5,  14'h00BC, 1'b1, 24'hFFFF00, 1'b1);

    rst = 1'b1; i_pix_ce = 1'b0; i_frame_start = 1'b0; i_show_en = 1'b0; i_pal_we = 1'b0;
    i_mem_select = '0; i_tile_code = '0; i_tile_offset = '0; i_rom_data = '0;
    i_pal_addr = '0; i_pal_data = '0;
    #1;
    check("reset addr", 32'(o_rom_addr), 32'h0);
    check("reset rsel", 32'(o_rom_sel), 32'h0);
    check("reset rgb", 32'({o_vga_r, o_vga_g, o_vga_b}), 32'h0);
    check("reset show", 32'(o_show_en), 32'h0);
    clk1; clk1;
    rst = 1'b0;
    clk1;

    for (int i = 0; i < 12; i++)
      run_vec(vt[i], $sformatf("vec%0d", i), 1'b0);

    // Hold: ce low with changing inputs must freeze everything.
    run_vec(vt[0], "hold pre", 1'b0);
    i_mem_select = 2'd1; i_tile_code = 8'hFF; i_tile_offset = 6'h3F; i_show_en = 1'b0;
    i_rom_data = 4'd0;
    for (int k = 0; k < 10; k++) clk1;
    check("hold addr", 32'(o_rom_addr), 32'h0485);
    check("hold rsel", 32'(o_rom_sel), 32'h0);
    check("hold rgb", 32'({o_vga_r, o_vga_g, o_vga_b}), 32'hFFFFFF);
    check("hold show", 32'(o_show_en), 32'h1);

    // Blink: phase flips only on the 8th frame pulse.
    frames(7);
    run_vec(mk(2'd0, 8'h01, 6'h01, 1'b1, 4'd9, 14'h0041, 1'b0, 24'hFFB8AE, 1'b1), "blink7 map", 1'b0);
    frames(1);
    run_vec(mk(2'd0, 8'h01, 6'h01, 1'b1, 4'd9, 14'h0041, 1'b0, 24'h000000, 1'b1), "blinkoff map9", 1'b0);
    run_vec(mk(2'd1, 8'h01, 6'h01, 1'b1, 4'd9, 14'h0041, 1'b1, 24'hFFB8AE, 1'b1), "blinkoff chr9", 1'b0);
    run_vec(mk(2'd0, 8'h01, 6'h01, 1'b1, 4'd7, 14'h0041, 1'b0, 24'hFFFFFF, 1'b1), "blinkoff map7", 1'b0);
    frames(8);
    run_vec(mk(2'd0, 8'h01, 6'h01, 1'b1, 4'd9, 14'h0041, 1'b0, 24'hFFB8AE, 1'b1), "blinkon map9", 1'b0);
    run_vec(mk(2'd1, 8'h01, 6'h01, 1'b1, 4'd9, 14'h0041, 1'b1, 24'hFFB8AE, 1'b1), "blinkon chr9", 1'b0);

    // Palette read-before-write on the stage-B clock.
    run_vec(mk(2'd0, 8'h03, 6'h03, 1'b1, 4'd3, 14'h00C3, 1'b0, 24'h00FFFF, 1'b1), "palwr same", 1'b1);
    run_vec(mk(2'd1, 8'h03, 6'h03, 1'b1, 4'd3, 14'h00C3, 1'b1, 24'h123456, 1'b1), "palwr next", 1'b0);

    // Async reset mid-stream with blink phase off and palette modified.
    frames(8);
    run_vec(vt[0], "prerst", 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst addr", 32'(o_rom_addr), 32'h0);
    check("rst rgb", 32'({o_vga_r, o_vga_g, o_vga_b}), 32'h0);
    check("rst show", 32'(o_show_en), 32'h0);
    clk1;
    rst = 1'b0;
    clk1;
    run_vec(mk(2'd1, 8'h03, 6'h03, 1'b1, 4'd3, 14'h00C3, 1'b1, 24'h00FFFF, 1'b1), "postrst pal3", 1'b0);
    run_vec(mk(2'd0, 8'h01, 6'h01, 1'b1, 4'd9, 14'h0041, 1'b0, 24'hFFB8AE, 1'b1), "postrst blink", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
